// File: rtl/fetch_hazard_ctrl.sv
// Fetch-side hazard controller: redirect squash, load-use stall,
// imem wait tracking with sticky timeout, saturating stall counter.
module fetch_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        imem_req,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        timeout_err,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [3:0]  FL_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [16:0] WT_LIM  = 17'(WAIT_TIMEOUT);

  state_t      r_state;
  logic [3:0]  r_flush_cnt;
  logic [15:0] r_wait_cnt;
  logic [15:0] r_stall_cnt;

  state_t      w_state_nxt;
  logic [3:0]  w_flush_nxt;
  logic [15:0] w_wait_nxt;
  logic        w_lu;
  logic [16:0] w_wait_inc;

  assign w_lu = ex_memread && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign w_wait_inc = {1'b0, r_wait_cnt} + 17'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_flush_cnt <= 4'd0;
      r_wait_cnt  <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_wait_cnt  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_cnt;
    w_wait_nxt  = r_wait_cnt;
    if (branch_taken && r_state != S_ERR) begin
      w_wait_nxt = 16'd0;
      if (FLUSH_CYCLES == 1) begin
        w_state_nxt = S_RUN;
        w_flush_nxt = 4'd0;
      end else begin
        w_state_nxt = S_FLUSH;
        w_flush_nxt = FL_LOAD;
      end
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (!w_lu && !imem_ready) begin
            w_state_nxt = S_WAIT;
            w_wait_nxt  = 16'd1;
          end
        end
        S_WAIT: begin
          if (imem_ready) begin
            w_state_nxt = S_RUN;
            w_wait_nxt  = 16'd0;
          end else begin
            w_wait_nxt = w_wait_inc[15:0];
            if (w_wait_inc >= WT_LIM)
              w_state_nxt = S_ERR;
          end
        end
        S_FLUSH: begin
          w_flush_nxt = r_flush_cnt - 4'd1;
          if (r_flush_cnt <= 4'd1) begin
            w_state_nxt = S_RUN;
            w_flush_nxt = 4'd0;
          end
        end
        S_ERR: begin
          w_state_nxt = S_ERR;
        end
      endcase
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst || r_state == S_ERR) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (branch_taken) begin
      imem_req   = 1'b1;
      pc_en      = 1'b1;
      pc_sel     = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      imem_req = 1'b1;
      unique case (r_state)
        S_RUN: begin
          if (w_lu) begin
            idex_flush = 1'b1;
          end else if (!imem_ready) begin
            ifid_flush = 1'b1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
        S_WAIT: begin
          pc_en      = imem_ready;
          ifid_en    = imem_ready;
          ifid_flush = !imem_ready;
        end
        S_FLUSH: begin
          pc_en      = imem_ready;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end
        S_ERR: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  assign timeout_err = (r_state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= 16'd0;
    else if (!pc_en && r_state != S_ERR && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Scoreboard bench for fetch_hazard_ctrl with FLUSH_CYCLES=3,
// WAIT_TIMEOUT=8; expected output vectors queued per driven cycle.
module tb_fetch_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ready = 1'b1;
  logic        branch_taken = 1'b0;
  logic        ex_memread = 1'b0;
  logic [4:0]  ex_rt = 5'd0;
  logic [4:0]  id_rs = 5'd1;
  logic [4:0]  id_rt = 5'd2;
  logic        imem_req, pc_en, pc_sel, ifid_en;
  logic        ifid_flush, idex_flush, timeout_err;
  logic [15:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  // {imem_req,pc_en,pc_sel,ifid_en,ifid_flush,idex_flush,timeout_err}
  localparam logic [6:0] RST = 7'b0000110;
  localparam logic [6:0] RUN = 7'b1101000;
  localparam logic [6:0] LU  = 7'b1000010;
  localparam logic [6:0] IMW = 7'b1000100;
  localparam logic [6:0] BR  = 7'b1111110;
  localparam logic [6:0] FL1 = 7'b1101100;
  localparam logic [6:0] FL0 = 7'b1001100;
  localparam logic [6:0] ERR = 7'b0000111;

  typedef struct {
    string       tag;
    logic [6:0]  o;
    bit          cs;
    logic [15:0] st;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  fetch_hazard_ctrl #(
    .FLUSH_CYCLES(3),
    .WAIT_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_ready(imem_ready),
    .branch_taken(branch_taken),
    .ex_memread(ex_memread),
    .ex_rt(ex_rt),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .imem_req(imem_req),
    .pc_en(pc_en),
    .pc_sel(pc_sel),
    .ifid_en(ifid_en),
    .ifid_flush(ifid_flush),
    .idex_flush(idex_flush),
    .timeout_err(timeout_err),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic rdy,
                     input logic br, input logic mr,
                     input logic [4:0] ert, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [6:0] o,
                     input bit cs, input logic [15:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    imem_ready   = rdy;
    branch_taken = br;
    ex_memread   = mr;
    ex_rt        = ert;
    id_rs        = rs;
    id_rt        = rt;
    e.tag = tag;
    e.o   = o;
    e.cs  = cs;
    e.st  = st;
    sbq.push_back(e);
  endtask

  task automatic nrm(input string tag, input logic [6:0] o,
                     input logic [15:0] st);
    cyc(tag, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2, o, 1, st);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk(mon_e.tag,
          {25'd0, imem_req, pc_en, pc_sel, ifid_en,
           ifid_flush, idex_flush, timeout_err},
          {25'd0, mon_e.o});
      if (mon_e.cs)
        chk({mon_e.tag, "/stall"}, {16'd0, stall_count},
            {16'd0, mon_e.st});
    end
  end

  initial begin
    cyc("rst0", 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, RST, 1, 16'd0);
    cyc("rst1", 1, 0, 1, 0, 5'd0, 5'd1, 5'd2, RST, 1, 16'd0);
    nrm("run0", RUN, 16'd0);
    nrm("run1", RUN, 16'd0);

    cyc("lu_rs", 0, 1, 0, 1, 5'd5, 5'd5, 5'd2, LU, 1, 16'd0);
    nrm("lu_rs_after", RUN, 16'd1);
    cyc("lu_r0", 0, 1, 0, 1, 5'd0, 5'd0, 5'd2, RUN, 1, 16'd1);
    cyc("lu_rt", 0, 1, 0, 1, 5'd7, 5'd1, 5'd7, LU, 1, 16'd1);
    nrm("lu_rt_after", RUN, 16'd2);
    cyc("lu_nomr", 0, 1, 0, 0, 5'd5, 5'd5, 5'd2, RUN, 1, 16'd2);

    cyc("br_c0", 0, 1, 1, 0, 5'd0, 5'd1, 5'd2, BR, 1, 16'd2);
    nrm("br_c1", FL1, 16'd2);
    nrm("br_c2", FL1, 16'd2);
    nrm("br_c3", RUN, 16'd2);

    cyc("sim_c0", 0, 0, 1, 1, 5'd5, 5'd5, 5'd2, BR, 1, 16'd2);
    nrm("sim_c1", FL1, 16'd2);
    cyc("sim_c2", 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, FL0, 1, 16'd2);
    nrm("sim_c3", RUN, 16'd3);

    cyc("rl_c0", 0, 1, 1, 0, 5'd0, 5'd1, 5'd2, BR, 1, 16'd3);
    nrm("rl_c1", FL1, 16'd3);
    cyc("rl_c2", 0, 1, 1, 0, 5'd0, 5'd1, 5'd2, BR, 1, 16'd3);
    nrm("rl_c3", FL1, 16'd3);
    nrm("rl_c4", FL1, 16'd3);
    nrm("rl_c5", RUN, 16'd3);

    for (int i = 0; i < 4; i++)
      cyc("wait", 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, IMW, 1, 16'(3 + i));
    nrm("wait_rel", RUN, 16'd7);
    nrm("wait_run", RUN, 16'd7);

    cyc("wlu_c0", 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, IMW, 1, 16'd7);
    cyc("wlu_c1", 0, 1, 0, 1, 5'd5, 5'd5, 5'd2, RUN, 1, 16'd8);
    nrm("wlu_c2", RUN, 16'd8);

    cyc("wbr_c0", 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, IMW, 1, 16'd8);
    cyc("wbr_c1", 0, 0, 1, 0, 5'd0, 5'd1, 5'd2, BR, 1, 16'd9);
    nrm("wbr_c2", FL1, 16'd9);
    nrm("wbr_c3", FL1, 16'd9);
    nrm("wbr_c4", RUN, 16'd9);

    for (int i = 0; i < 8; i++)
      cyc("to_wait", 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, IMW, 1, 16'(9 + i));
    cyc("to_err", 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, ERR, 1, 16'd17);
    cyc("to_br", 0, 1, 1, 0, 5'd0, 5'd1, 5'd2, ERR, 1, 16'd17);
    nrm("to_hold", ERR, 16'd17);
    cyc("to_rst", 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, ERR, 1, 16'd17);
    nrm("to_clr", RUN, 16'd0);

    cyc("mrf_c0", 0, 1, 1, 0, 5'd0, 5'd1, 5'd2, BR, 1, 16'd0);
    cyc("mrf_c1", 1, 1, 0, 0, 5'd0, 5'd1, 5'd2, RST, 1, 16'd0);
    nrm("mrf_c2", RUN, 16'd0);
    cyc("mrw_c0", 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, IMW, 1, 16'd0);
    cyc("mrw_c1", 1, 0, 0, 0, 5'd0, 5'd1, 5'd2, RST, 1, 16'd1);
    nrm("mrw_c2", RUN, 16'd0);

    for (int i = 0; i < 65540; i++)
      cyc("sat", 0, 1, 0, 1, 5'd5, 5'd5, 5'd0, LU, i >= 65533,
          (i > 65535) ? 16'hFFFF : 16'(i));
    nrm("sat_end", RUN, 16'hFFFF);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
